// File: rtl/msu_pkg.sv
// Shared types and defaults for the modular-squaring sequencer.
package msu_pkg;

   localparam int TotalWordBits  = 16;
   localparam int DefLoopLatency = 2;
   localparam int DefIterBits    = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } msu_seq_state_e;

endpackage

// File: rtl/msu_seq_chan.sv
// One squaring chain: state, remaining count, latched start value and
// issue/complete requests. Requests are only raised when this channel owns
// the current slot, so the top level never sees two active channels at once.
module msu_seq_chan
   import msu_pkg::*;
#(
   parameter int WordBits = TotalWordBits,
   parameter int IterBits = DefIterBits
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                slot_hit_i,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [IterBits-1:0] iter_i,
   input  logic [WordBits-1:0] sq_nr_i,
   input  logic [WordBits-1:0] sq_r_i,
   input  logic [WordBits-1:0] dp_nr_i,
   input  logic [WordBits-1:0] dp_r_i,
   output logic                busy_o,
   output logic                issue_o,
   output logic                done_o,
   output logic [WordBits-1:0] op_nr_o,
   output logic [WordBits-1:0] op_r_o
);

   msu_seq_state_e      state_q, state_d;
   logic [IterBits-1:0] rem_q, rem_d;
   logic [WordBits-1:0] in_nr_q, in_r_q;
   logic                load_en;

   // A start is only taken by an idle channel and loses to an abort.
   assign load_en = (state_q == IDLE) && start_i && !abort_i;
   assign busy_o  = (state_q != IDLE);

   // Next state, remaining count, and the operand offered to the top level.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      issue_o = 1'b0;
      done_o  = 1'b0;
      op_nr_o = in_nr_q;
      op_r_o  = in_r_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = LOAD;
               rem_d   = iter_i;
            end
         end
         LOAD: begin
            if (slot_hit_i) begin
               if (rem_q == '0) begin
                  done_o  = 1'b1;
                  state_d = IDLE;
               end else begin
                  issue_o = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (slot_hit_i) begin
               // The datapath return of our previous issue is due right now.
               op_nr_o = dp_nr_i;
               op_r_o  = dp_r_i;
               rem_d   = rem_q - IterBits'(1);
               if (rem_q == IterBits'(1)) begin
                  done_o  = 1'b1;
                  state_d = IDLE;
               end else begin
                  issue_o = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Abort wins over everything, including a completion in this cycle.
      if (abort_i) begin
         state_d = IDLE;
         rem_d   = '0;
         issue_o = 1'b0;
         done_o  = 1'b0;
      end
   end

   // Channel state and remaining count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   // Start value register; data only, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (load_en) begin
         in_nr_q <= sq_nr_i;
         in_r_q  <= sq_r_i;
      end
   end

endmodule

// File: rtl/msu_seq.sv
// Multi-channel iteration sequencer: interleaves independent squaring chains
// into the slots of the squarer/reducer loop, one slot per channel.
module msu_seq
   import msu_pkg::*;
#(
   parameter int WordBits    = TotalWordBits,
   parameter int LoopLatency = DefLoopLatency,
   parameter int Channels    = 2,
   parameter int IterBits    = DefIterBits,
   parameter int ChBits      = (Channels > 1) ? $clog2(Channels) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [ChBits-1:0]   start_ch_i,
   input  logic [IterBits-1:0] iter_i,
   input  logic [WordBits-1:0] sq_nr_i,
   input  logic [WordBits-1:0] sq_r_i,
   input  logic                abort_i,
   input  logic [ChBits-1:0]   abort_ch_i,
   output logic [Channels-1:0] busy_o,
   output logic                dp_valid_o,
   output logic [WordBits-1:0] dp_nr_o,
   output logic [WordBits-1:0] dp_r_o,
   input  logic [WordBits-1:0] dp_nr_i,
   input  logic [WordBits-1:0] dp_r_i,
   output logic                res_valid_o,
   output logic [ChBits-1:0]   res_ch_o,
   output logic [WordBits-1:0] res_nr_o,
   output logic [WordBits-1:0] res_r_o
);

   localparam int SlotBits = (LoopLatency > 1) ? $clog2(LoopLatency) : 1;

   if (LoopLatency < 2 || Channels < 1 || Channels > LoopLatency) begin : g_param_err
      $error("msu_seq: need LoopLatency >= 2 and 1 <= Channels <= LoopLatency");
   end

   logic [SlotBits-1:0] slot_q;
   logic [Channels-1:0] issue, done;
   logic [WordBits-1:0] op_nr [Channels];
   logic [WordBits-1:0] op_r  [Channels];

   logic                issue_any, done_any;
   logic [WordBits-1:0] mux_nr, mux_r;
   logic [ChBits-1:0]   mux_ch;

   logic                dp_valid_q, res_valid_q;
   logic [WordBits-1:0] dp_nr_q, dp_r_q, res_nr_q, res_r_q;
   logic [ChBits-1:0]   res_ch_q;

   // Slot counter: channel c may only act while slot_q == c.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q <= '0;
      end else if (slot_q == SlotBits'(LoopLatency - 1)) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_q + SlotBits'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < Channels; gi++) begin : g_chan
         msu_seq_chan #(
            .WordBits (WordBits),
            .IterBits (IterBits)
         ) u_chan (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .slot_hit_i (slot_q == SlotBits'(gi)),
            .start_i    (start_i && (start_ch_i == ChBits'(gi))),
            .abort_i    (abort_i && (abort_ch_i == ChBits'(gi))),
            .iter_i     (iter_i),
            .sq_nr_i    (sq_nr_i),
            .sq_r_i     (sq_r_i),
            .dp_nr_i    (dp_nr_i),
            .dp_r_i     (dp_r_i),
            .busy_o     (busy_o[gi]),
            .issue_o    (issue[gi]),
            .done_o     (done[gi]),
            .op_nr_o    (op_nr[gi]),
            .op_r_o     (op_r[gi])
         );
      end
   endgenerate

   // One-hot AND-OR mux: only the slot owner can raise a request.
   always_comb begin
      issue_any = 1'b0;
      done_any  = 1'b0;
      mux_nr    = '0;
      mux_r     = '0;
      mux_ch    = '0;
      for (int c = 0; c < Channels; c++) begin
         if (issue[c]) issue_any = 1'b1;
         if (issue[c] || done[c]) begin
            mux_nr = mux_nr | op_nr[c];
            mux_r  = mux_r | op_r[c];
         end
         if (done[c]) begin
            done_any = 1'b1;
            mux_ch   = mux_ch | ChBits'(c);
         end
      end
   end

   // Datapath issue and result registers; operands and results hold between events.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dp_valid_q  <= 1'b0;
         dp_nr_q     <= '0;
         dp_r_q      <= '0;
         res_valid_q <= 1'b0;
         res_ch_q    <= '0;
         res_nr_q    <= '0;
         res_r_q     <= '0;
      end else begin
         dp_valid_q  <= issue_any;
         res_valid_q <= done_any;
         if (issue_any) begin
            dp_nr_q <= mux_nr;
            dp_r_q  <= mux_r;
         end
         if (done_any) begin
            res_ch_q <= mux_ch;
            res_nr_q <= mux_nr;
            res_r_q  <= mux_r;
         end
      end
   end

   assign dp_valid_o  = dp_valid_q;
   assign dp_nr_o     = dp_nr_q;
   assign dp_r_o      = dp_r_q;
   assign res_valid_o = res_valid_q;
   assign res_ch_o    = res_ch_q;
   assign res_nr_o    = res_nr_q;
   assign res_r_o     = res_r_q;

endmodule

// File: tb/tb_msu_seq.sv
// Scoreboard bench for msu_seq with a one-register datapath f(nr,r) = (nr+1, r+2).
module tb_msu_seq;
   import msu_pkg::*;

   localparam int W   = 16;
   localparam int L   = 2;
   localparam int CH  = 2;
   localparam int IB  = 32;
   localparam int CB  = 2;
   localparam int BIG = 1 << 30;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic [CB-1:0] start_ch_i = '0;
   logic [IB-1:0] iter_i = '0;
   logic [W-1:0]  sq_nr_i = '0, sq_r_i = '0;
   logic          abort_i = 1'b0;
   logic [CB-1:0] abort_ch_i = '0;
   logic [CH-1:0] busy_o;
   logic          dp_valid_o, res_valid_o;
   logic [W-1:0]  dp_nr_o, dp_r_o, ret_nr, ret_r, res_nr_o, res_r_o;
   logic [CB-1:0] res_ch_o;

   always #5 clk = ~clk;

   msu_seq #(
      .WordBits(W), .LoopLatency(L), .Channels(CH), .IterBits(IB), .ChBits(CB)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .start_i(start_i), .start_ch_i(start_ch_i), .iter_i(iter_i),
      .sq_nr_i(sq_nr_i), .sq_r_i(sq_r_i),
      .abort_i(abort_i), .abort_ch_i(abort_ch_i),
      .busy_o(busy_o),
      .dp_valid_o(dp_valid_o), .dp_nr_o(dp_nr_o), .dp_r_o(dp_r_o),
      .dp_nr_i(ret_nr), .dp_r_i(ret_r),
      .res_valid_o(res_valid_o), .res_ch_o(res_ch_o),
      .res_nr_o(res_nr_o), .res_r_o(res_r_o)
   );

   // External datapath: one register, never reset, so stale values survive a reset.
   always @(posedge clk) begin
      ret_nr <= dp_nr_o + 16'd1;
      ret_r  <= dp_r_o + 16'd2;
   end

   // Cycle index since reset release; slot of cycle k is k mod L.
   int cyc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Reference model: one record per channel describing its current chain.
   bit          m_val   [CH];
   int          m_from  [CH];
   int          m_s     [CH];
   int          m_n     [CH];
   int          m_end   [CH];
   int          m_abort [CH];
   logic [W-1:0] m_nr   [CH];
   logic [W-1:0] m_r    [CH];

   typedef struct {
      int           ch;
      int           due;
      logic [W-1:0] nr;
      logic [W-1:0] r;
   } exp_t;
   exp_t exp_q[$];

   int vectors = 0;
   int miscompares = 0;

   function automatic int end_eff(int c);
      return (m_abort[c] + 1 < m_end[c]) ? m_abort[c] + 1 : m_end[c];
   endfunction

   function automatic bit m_busy(int c, int k);
      return m_val[c] && (k >= m_from[c]) && (k < end_eff(c));
   endfunction

   task automatic chk(string nm, longint act, longint req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_val[c]   = 1'b0;
         m_abort[c] = BIG;
      end
      exp_q.delete();
   endtask

   // Drive one cycle of stimulus and update the model with what must happen.
   task automatic drive(bit st, int sch, int it, logic [W-1:0] nr, logic [W-1:0] r,
                        bit ab, int ach);
      int   k;
      int   s;
      exp_t e;
      @(posedge clk);
      #1;
      k          = cyc;
      start_i    = st;
      start_ch_i = CB'(sch);
      iter_i     = IB'(it);
      sq_nr_i    = nr;
      sq_r_i     = r;
      abort_i    = ab;
      abort_ch_i = CB'(ach);
      if (ab && ach < CH && m_busy(ach, k)) begin
         m_abort[ach] = k;
         for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].ch == ach) exp_q.delete(i);
      end
      if (st && sch < CH && !m_busy(sch, k) && !(ab && ach == sch)) begin
         s = k + 1;
         while (s % L != sch) s++;
         m_val[sch]   = 1'b1;
         m_from[sch]  = k + 1;
         m_s[sch]     = s;
         m_n[sch]     = it;
         m_end[sch]   = s + it * L + 1;
         m_abort[sch] = BIG;
         m_nr[sch]    = nr;
         m_r[sch]     = r;
         e.ch  = sch;
         e.due = m_end[sch];
         e.nr  = nr + W'(it);
         e.r   = r + W'(2 * it);
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, 0, 0);
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_dp_valid"}, dp_valid_o, 0);
      chk({tag, "_dp_nr"}, dp_nr_o, 0);
      chk({tag, "_dp_r"}, dp_r_o, 0);
      chk({tag, "_res_valid"}, res_valid_o, 0);
      chk({tag, "_res_ch"}, res_ch_o, 0);
      chk({tag, "_res_nr"}, res_nr_o, 0);
      chk({tag, "_res_r"}, res_r_o, 0);
   endtask

   // Monitor: per-cycle busy/issue checks and scoreboard pops on completions.
   always @(negedge clk) begin
      logic [CH-1:0] e_busy;
      bit            e_dpv;
      logic [W-1:0]  e_nr, e_r;
      int            j, idx;
      if (rst_n) begin
         e_busy = '0;
         e_dpv  = 1'b0;
         e_nr   = '0;
         e_r    = '0;
         for (int c = 0; c < CH; c++) begin
            e_busy[c] = m_busy(c, cyc);
            if (m_val[c] && m_n[c] > 0 && cyc >= m_s[c] + 1 && cyc <= m_abort[c] &&
                cyc < m_s[c] + 1 + m_n[c] * L && ((cyc - m_s[c] - 1) % L) == 0) begin
               j     = (cyc - m_s[c] - 1) / L;
               e_dpv = 1'b1;
               e_nr  = m_nr[c] + W'(j);
               e_r   = m_r[c] + W'(2 * j);
            end
         end
         chk("busy", busy_o, e_busy);
         chk("dp_valid", dp_valid_o, e_dpv);
         if (e_dpv && dp_valid_o) begin
            chk("dp_nr", dp_nr_o, e_nr);
            chk("dp_r", dp_r_o, e_r);
         end
         if (res_valid_o) begin
            if (exp_q.size() == 0) begin
               chk("res_unexpected", 1, 0);
            end else begin
               idx = 0;
               for (int i = 1; i < exp_q.size(); i++)
                  if (exp_q[i].due < exp_q[idx].due) idx = i;
               chk("res_cycle", cyc, exp_q[idx].due);
               chk("res_ch", res_ch_o, exp_q[idx].ch);
               chk("res_nr", res_nr_o, exp_q[idx].nr);
               chk("res_r", res_r_o, exp_q[idx].r);
               $display("cycle %0d: result ch=%0d nr=%h r=%h", cyc, res_ch_o, res_nr_o, res_r_o);
               exp_q.delete(idx);
            end
         end
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due < cyc) begin
               chk("res_missing", exp_q[i].due, cyc);
               exp_q.delete(i);
            end
         end
      end
   end

   initial begin
      int e;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // Single chain, then two interleaved chains.
      drive(1, 0, 3, 16'h1000, 16'h2000, 0, 0);
      idle(10);
      drive(1, 0, 5, 16'h0100, 16'h0a00, 0, 0);
      drive(1, 1, 2, 16'h0300, 16'h0b00, 0, 0);
      idle(14);

      // Zero iterations.
      drive(1, 1, 0, 16'hbeef, 16'hcafe, 0, 0);
      idle(4);

      // Abort ch0 in its completion cycle, then restart it.
      drive(1, 0, 1, 16'h4444, 16'h5555, 0, 0);
      e = m_end[0];
      while (cyc + 1 < e - 1) idle(1);
      drive(0, 0, 0, '0, '0, 1, 0);
      idle(2);
      drive(1, 0, 1, 16'h7000, 16'h7100, 0, 0);
      idle(6);

      // Ignored requests: busy channel, out-of-range channel, abort+start same channel.
      drive(1, 1, 4, 16'h0010, 16'h0020, 0, 0);
      drive(1, 1, 2, 16'h9999, 16'h9999, 0, 0);
      drive(1, 3, 2, 16'h8888, 16'h8888, 0, 0);
      drive(1, 0, 2, 16'h7777, 16'h7777, 1, 0);
      drive(1, 2, 1, 16'h6666, 16'h6666, 1, 3);
      idle(12);

      // Asynchronous reset while both chains run with a return in flight.
      drive(1, 0, 6, 16'h0a0a, 16'h0b0b, 0, 0);
      drive(1, 1, 6, 16'h0c0c, 16'h0d0d, 0, 0);
      idle(5);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all_zero("midrun_reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1, 0, 2, 16'h1234, 16'h5678, 0, 0);
      idle(10);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 3) == 0, int'($urandom % 4), int'($urandom % 5),
               W'($urandom), W'($urandom), ($urandom % 12) == 0, int'($urandom % 4));
      end
      idle(40);
      chk("drain_pending", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
